prt_dp_axil_lb_bridge: RTL

PRT_DP_AXIL_LB_BRIDGE -- requirements
Module: prt_dp_axil_lb_bridge

---
 rtl/prt_dp_axil_lb_bridge_pkg.sv | 19 +
 rtl/prt_dp_axil_lb_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prt_dp_axil_lb_bridge_pkg.sv
// Shared DP library definitions for the AXI-Lite to local-bus bridge:
// FSM state encoding, AXI response codes and timeout counter width.
package prt_dp_axil_lb_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RSP,
    S_RD,
    S_RD_WAIT,
    S_RD_RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int TMO_W = 16;

endpackage

// File: rtl/prt_dp_axil_lb_bridge.sv
// AXI-Lite slave to single-strobe local bus; one LB transaction outstanding,
// AW/W/AR buffered one deep, read timeout returns SLVERR.
module prt_dp_axil_lb_bridge
  import prt_dp_axil_lb_bridge_pkg::*;
#(
  parameter int P_ADR_WIDTH = 32,
  parameter int P_TIMEOUT   = 255
) (
  input  logic                   CLK_IN,
  input  logic                   RST_N_IN,
  input  logic [P_ADR_WIDTH-1:0] AXIL_AWADR_IN,
  input  logic                   AXIL_AWVALID_IN,
  output logic                   AXIL_AWREADY_OUT,
  input  logic [31:0]            AXIL_WDATA_IN,
  input  logic                   AXIL_WVALID_IN,
  output logic                   AXIL_WREADY_OUT,
  output logic [1:0]             AXIL_BRESP_OUT,
  output logic                   AXIL_BVALID_OUT,
  input  logic                   AXIL_BREADY_IN,
  input  logic [P_ADR_WIDTH-1:0] AXIL_ARADR_IN,
  input  logic                   AXIL_ARVALID_IN,
  output logic                   AXIL_ARREADY_OUT,
  output logic [31:0]            AXIL_RDATA_OUT,
  output logic [1:0]             AXIL_RRESP_OUT,
  output logic                   AXIL_RVALID_OUT,
  input  logic                   AXIL_RREADY_IN,
  output logic [P_ADR_WIDTH-1:0] LB_ADR_OUT,
  output logic                   LB_WR_OUT,
  output logic                   LB_RD_OUT,
  output logic [31:0]            LB_DIN_OUT,
  input  logic [31:0]            LB_DOUT_IN,
  input  logic                   LB_VLD_IN
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(P_TIMEOUT);

  state_t                   state_q, state_d;
  logic                     aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic [P_ADR_WIDTH-1:0]   aw_adr_q, aw_adr_d, ar_adr_q, ar_adr_d;
  logic [31:0]              w_dat_q, w_dat_d;
  logic                     prefer_wr_q, prefer_wr_d;
  logic [TMO_W-1:0]         cnt_q, cnt_d;
  logic                     awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                     bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [P_ADR_WIDTH-1:0]   lb_adr_q, lb_adr_d;
  logic [31:0]              lb_din_q, lb_din_d;
  logic                     lb_wr_q, lb_wr_d, lb_rd_q, lb_rd_d;

  logic                     aw_hs, w_hs, ar_hs, wr_pend, rd_pend;

  always_comb begin
    aw_hs = AXIL_AWVALID_IN & awready_q;
    w_hs  = AXIL_WVALID_IN & wready_q;
    ar_hs = AXIL_ARVALID_IN & arready_q;

    // Holders see this cycle's handshake so IDLE can grant without an extra cycle.
    aw_full_d   = aw_full_q | aw_hs;
    aw_adr_d    = aw_hs ? AXIL_AWADR_IN : aw_adr_q;
    w_full_d    = w_full_q | w_hs;
    w_dat_d     = w_hs ? AXIL_WDATA_IN : w_dat_q;
    ar_full_d   = ar_full_q | ar_hs;
    ar_adr_d    = ar_hs ? AXIL_ARADR_IN : ar_adr_q;
    wr_pend     = aw_full_d & w_full_d;
    rd_pend     = ar_full_d;

    state_d     = state_q;
    prefer_wr_d = prefer_wr_q;
    cnt_d       = cnt_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    lb_adr_d    = lb_adr_q;
    lb_din_d    = lb_din_q;
    lb_wr_d     = 1'b0;
    lb_rd_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Fairness flag only moves when both types contend.
        if (wr_pend && (!rd_pend || prefer_wr_q)) begin
          state_d  = S_WR;
          lb_wr_d  = 1'b1;
          lb_adr_d = aw_adr_d;
          lb_din_d = w_dat_d;
          if (rd_pend) prefer_wr_d = 1'b0;
        end else if (rd_pend) begin
          state_d  = S_RD;
          lb_rd_d  = 1'b1;
          lb_adr_d = ar_adr_d;
          if (wr_pend) prefer_wr_d = 1'b1;
        end
      end
      S_WR: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        bvalid_d  = 1'b1;
        state_d   = S_WR_RSP;
      end
      S_WR_RSP: begin
        if (AXIL_BREADY_IN) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_RD: begin
        ar_full_d = 1'b0;
        cnt_d     = TMO_LOAD;
        state_d   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (LB_VLD_IN) begin
          rdata_d  = LB_DOUT_IN;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          state_d  = S_RD_RSP;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= 16'd1) begin
            cnt_d    = '0;
            rdata_d  = 32'h0;
            rresp_d  = RESP_SLVERR;
            rvalid_d = 1'b1;
            state_d  = S_RD_RSP;
          end
        end
      end
      S_RD_RSP: begin
        if (AXIL_RREADY_IN) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = !aw_full_d && (state_d != S_WR) && (state_d != S_WR_RSP);
    wready_d  = !w_full_d && (state_d != S_WR) && (state_d != S_WR_RSP);
    arready_d = !ar_full_d;
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state_q     <= S_IDLE;
      aw_full_q   <= 1'b0;
      aw_adr_q    <= '0;
      w_full_q    <= 1'b0;
      w_dat_q     <= '0;
      ar_full_q   <= 1'b0;
      ar_adr_q    <= '0;
      prefer_wr_q <= 1'b1;
      cnt_q       <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      lb_adr_q    <= '0;
      lb_din_q    <= '0;
      lb_wr_q     <= 1'b0;
      lb_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_full_q   <= aw_full_d;
      aw_adr_q    <= aw_adr_d;
      w_full_q    <= w_full_d;
      w_dat_q     <= w_dat_d;
      ar_full_q   <= ar_full_d;
      ar_adr_q    <= ar_adr_d;
      prefer_wr_q <= prefer_wr_d;
      cnt_q       <= cnt_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      lb_adr_q    <= lb_adr_d;
      lb_din_q    <= lb_din_d;
      lb_wr_q     <= lb_wr_d;
      lb_rd_q     <= lb_rd_d;
    end
  end

  assign AXIL_AWREADY_OUT = awready_q;
  assign AXIL_WREADY_OUT  = wready_q;
  assign AXIL_ARREADY_OUT = arready_q;
  assign AXIL_BVALID_OUT  = bvalid_q;
  assign AXIL_BRESP_OUT   = RESP_OKAY;
  assign AXIL_RVALID_OUT  = rvalid_q;
  assign AXIL_RDATA_OUT   = rdata_q;
  assign AXIL_RRESP_OUT   = rresp_q;
  assign LB_ADR_OUT       = lb_adr_q;
  assign LB_DIN_OUT       = lb_din_q;
  assign LB_WR_OUT        = lb_wr_q;
  assign LB_RD_OUT        = lb_rd_q;

endmodule
